// File: rtl/sync_ram_1r1w.sv
// sync_ram_1r1w: single-clock RAM with one write port, one read port and a
// registered read output.
//
// Ports:
//   clk_i       clock, all state updates on the rising edge
//   reset_i     asynchronous active-high reset; clears rd_data_o only
//   wr_valid_i  write enable for this cycle
//   wr_data_i   write data (width_p bits)
//   wr_addr_i   write word address
//   rd_valid_i  read enable for this cycle
//   rd_addr_i   read word address
//   rd_data_o   registered read data, one cycle after rd_valid_i
//
// The storage array is named mem so a parent can preload it hierarchically.
// Reset never touches mem. A same-address read and write on one edge
// returns the old contents (read-first).

module sync_ram_1r1w #(
  parameter int width_p = 32,
  parameter int depth_p = 1024,
  localparam int addr_width_lp = $clog2(depth_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     wr_valid_i,
  input  logic [width_p-1:0]       wr_data_i,
  input  logic [addr_width_lp-1:0] wr_addr_i,
  input  logic                     rd_valid_i,
  input  logic [addr_width_lp-1:0] rd_addr_i,
  output logic [width_p-1:0]       rd_data_o
);

  localparam bit pow2_lp = (depth_p == (1 << addr_width_lp));
  localparam logic [31:0] depth_lp = 32'(depth_p);

  logic [width_p-1:0] mem [depth_p];

  logic wr_in_range;
  logic rd_in_range;

  // With a power-of-two depth every encodable address is a real entry.
  if (pow2_lp) begin : g_pow2
    assign wr_in_range = 1'b1;
    assign rd_in_range = 1'b1;
  end else begin : g_npow2
    assign wr_in_range = (32'(wr_addr_i) < depth_lp);
    assign rd_in_range = (32'(rd_addr_i) < depth_lp);
  end

  // Writes are held off while reset is asserted; contents are retained.
  always_ff @(posedge clk_i) begin
    if (!reset_i && wr_valid_i && wr_in_range) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Nonblocking read of mem sees the pre-edge value, giving read-first.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_data_o <= '0;
    end else if (rd_valid_i) begin
      rd_data_o <= rd_in_range ? mem[rd_addr_i] : '0;
    end
  end

endmodule

// File: tb/tb_sync_ram_1r1w.sv
module tb_sync_ram_1r1w;

  localparam int W   = 32;
  localparam int D   = 1024;
  localparam int AW  = 10;
  localparam int W6  = 8;
  localparam int D6  = 6;
  localparam int AW6 = 3;

  logic clk_i = 1'b0;
  logic reset_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          wr_valid = 1'b0;
  logic [W-1:0]  wr_data  = '0;
  logic [AW-1:0] wr_addr  = '0;
  logic          rd_valid = 1'b0;
  logic [AW-1:0] rd_addr  = '0;
  logic [W-1:0]  rd_data;

  logic           d6_wr_valid = 1'b0;
  logic [W6-1:0]  d6_wr_data  = '0;
  logic [AW6-1:0] d6_wr_addr  = '0;
  logic           d6_rd_valid = 1'b0;
  logic [AW6-1:0] d6_rd_addr  = '0;
  logic [W6-1:0]  d6_rd_data;

  sync_ram_1r1w #(.width_p(W), .depth_p(D)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .wr_valid_i(wr_valid), .wr_data_i(wr_data), .wr_addr_i(wr_addr),
    .rd_valid_i(rd_valid), .rd_addr_i(rd_addr), .rd_data_o(rd_data)
  );

  sync_ram_1r1w #(.width_p(W6), .depth_p(D6)) dut6 (
    .clk_i(clk_i), .reset_i(reset_i),
    .wr_valid_i(d6_wr_valid), .wr_data_i(d6_wr_data), .wr_addr_i(d6_wr_addr),
    .rd_valid_i(d6_rd_valid), .rd_addr_i(d6_rd_addr), .rd_data_o(d6_rd_data)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: plain arrays of word contents plus "has been written".
  logic [W-1:0]  model [D];
  bit            known [D];
  logic [W-1:0]  exp_rd = '0;
  bit            exp_known = 1'b1;

  logic [W6-1:0] m6 [8];
  bit            k6 [8];
  logic [W6-1:0] exp6 = '0;
  bit            exp6_known = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock cycle on the main instance; inputs driven on the falling edge.
  task automatic cyc(input string tag, input bit wv, input int wa, input logic [W-1:0] wd,
                     input bit rv, input int ra);
    wr_valid = wv; wr_addr = AW'(wa); wr_data = wd;
    rd_valid = rv; rd_addr = AW'(ra);
    @(posedge clk_i);
    if (reset_i) begin
      exp_rd = '0; exp_known = 1'b1;
    end else begin
      if (rv) begin exp_rd = model[ra]; exp_known = known[ra]; end
      if (wv) begin model[wa] = wd; known[wa] = 1'b1; end
    end
    #1;
    if (exp_known) chk(tag, rd_data, exp_rd);
    @(negedge clk_i);
    wr_valid = 1'b0; rd_valid = 1'b0;
  endtask

  task automatic cyc6(input string tag, input bit wv, input int wa, input logic [W6-1:0] wd,
                      input bit rv, input int ra);
    d6_wr_valid = wv; d6_wr_addr = AW6'(wa); d6_wr_data = wd;
    d6_rd_valid = rv; d6_rd_addr = AW6'(ra);
    @(posedge clk_i);
    if (rv) begin
      if (ra >= D6) begin exp6 = '0; exp6_known = 1'b1; end
      else begin exp6 = m6[ra]; exp6_known = k6[ra]; end
    end
    if (wv && wa < D6) begin m6[wa] = wd; k6[wa] = 1'b1; end
    #1;
    if (exp6_known) chk(tag, 32'(d6_rd_data), 32'(exp6));
    @(negedge clk_i);
    d6_wr_valid = 1'b0; d6_rd_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < D; i++) begin model[i] = '0; known[i] = 1'b0; end
    for (int i = 0; i < 8; i++) begin m6[i] = '0; k6[i] = 1'b0; end

    #1 reset_i = 1'b1;
    #1;
    chk("reset_init", rd_data, 32'h0);
    chk("reset_init6", 32'(d6_rd_data), 32'h0);
    @(negedge clk_i);
    reset_i = 1'b0;
    exp_rd = '0; exp_known = 1'b1;

    // Preload, then asynchronous reset mid-cycle.
    cyc("pre5_wr", 1, 5, 32'h1122_3344, 0, 0);
    cyc("dead_wr", 1, 9, 32'hDEAD_BEEF, 0, 0);
    cyc("dead_rd", 0, 0, '0, 1, 9);
    #2 reset_i = 1'b1;
    #1;
    chk("async_reset", rd_data, 32'h0);
    exp_rd = '0; exp_known = 1'b1;
    cyc("reset_wr_sup", 1, 5, 32'hBAD0_BAD0, 1, 5);
    reset_i = 1'b0;
    cyc("pre5_survives", 0, 0, '0, 1, 5);

    // Basic write/read, neighbour isolation, hold.
    cyc("wr4", 1, 4, 32'h4444_0004, 0, 0);
    cyc("wr3", 1, 3, 32'hA5A5_0001, 0, 0);
    cyc("rd4", 0, 0, '0, 1, 4);
    cyc("rd3", 0, 0, '0, 1, 3);
    cyc("hold_wr3", 1, 3, 32'h0, 0, 0);
    cyc("hold_idle", 0, 0, '0, 0, 0);
    cyc("rd3_new", 0, 0, '0, 1, 3);

    // Read-during-write, same address.
    cyc("wr7", 1, 7, 32'h1111_1111, 0, 0);
    cyc("rdw7_old", 1, 7, 32'h2222_2222, 1, 7);
    cyc("rd7_new", 0, 0, '0, 1, 7);

    // Boundary addresses, back-to-back reads.
    cyc("wr0", 1, 0, 32'hCAFE_0000, 0, 0);
    cyc("wr_top", 1, D-1, 32'h0000_BEEF, 0, 0);
    cyc("rd0", 0, 0, '0, 1, 0);
    cyc("rd_top", 0, 0, '0, 1, D-1);
    cyc("rd0_again", 1, 12, 32'h0C0C_0C0C, 1, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      int wa, ra;
      wa = ($urandom_range(0, 7) == 0) ? D-1 : int'($urandom_range(0, 15));
      ra = ($urandom_range(0, 7) == 0) ? D-1 : int'($urandom_range(0, 15));
      cyc($sformatf("rand%0d", i), bit'($urandom_range(0, 1)), wa, W'($urandom),
          bit'($urandom_range(0, 1)), ra);
    end

    // Non-power-of-two depth: out-of-range accesses.
    for (int i = 0; i < D6; i++) cyc6($sformatf("d6_wr%0d", i), 1, i, W6'(8'h10 + i), 0, 0);
    cyc6("d6_wr_oor7", 1, 7, 8'h55, 0, 0);
    for (int i = 0; i < D6; i++) cyc6($sformatf("d6_rd%0d", i), 0, 0, '0, 1, i);
    cyc6("d6_rd_oor7", 0, 0, '0, 1, 7);
    cyc6("d6_wr_oor6", 1, 6, 8'h66, 1, 5);
    cyc6("d6_rd_oor6", 0, 0, '0, 1, 6);
    cyc6("d6_rd5_final", 0, 0, '0, 1, 5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sync_ram_1r1w.md
Name: sync_ram_1r1w

Overview:
- Single-clock, one-read-port/one-write-port synchronous RAM with a registered read output.
- Used as the storage array inside data_memory and other memory wrappers.
- The wrapper performs read-modify-write for partial-word stores: it issues a read, then writes back merged data one cycle later. The RAM itself has no byte enables.

Parameters:
- width_p, 32, data word width in bits (≥1).
- depth_p, 1024, number of words (≥2; need not be a power of two).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- wr_valid_i  input  1  write enable for this cycle.
- wr_data_i  input  width_p  write data.
- wr_addr_i  input  $clog2(depth_p)  write word address.
- rd_valid_i  input  1  read enable for this cycle.
- rd_addr_i  input  $clog2(depth_p)  read word address.
- rd_data_o  output  width_p  registered read data.

Behaviour:
- Storage array:
  - Declared as an unpacked array named mem, width_p bits by depth_p entries, indices 0..depth_p-1.
  - It is directly reachable hierarchically (instance.mem), so a parent can preload it with $readmemh.
  - Contents are never cleared by reset; there is no reset loop over mem.
  - Uninitialised entries read as X in simulation.
- Reset:
  - While reset_i is high, rd_data_o = 0, forced asynchronously on reset_i rising, not waiting for a clock.
  - Writes are suppressed while reset_i is high.
  - First clock edge after reset_i falls behaves normally.
- Write:
  - On posedge clk_i with wr_valid_i=1 and wr_addr_i < depth_p: mem[wr_addr_i] <= wr_data_i.
  - With wr_valid_i=0, no change.
- Read:
  - On posedge clk_i with rd_valid_i=1: rd_data_o <= mem[rd_addr_i].
  - Latency is exactly 1 cycle: data is valid from the clock edge that sampled rd_valid_i until the next edge that samples rd_valid_i=1.
  - With rd_valid_i=0: rd_data_o holds its previous value.
- Read-during-write, same address, same edge: read-first. rd_data_o returns the old contents; the new value is visible to a read on the following edge.
- Read and write to different addresses on the same edge: fully independent.
- Out-of-range address (only possible when depth_p is not a power of two):
  - Write is ignored.
  - Read loads 0 into rd_data_o.
- Addresses are word addresses; there is no byte-lane or mask logic.
- No combinational path from any input to rd_data_o.
- Optional simulation assertions: wr_addr_i/rd_addr_i not X when the corresponding valid is 1.

Test Plan:
- Reset: assert reset_i mid-cycle after loading rd_data_o=0xDEADBEEF -> rd_data_o=0 immediately, before the next clk edge. A preload of mem[5]=0x11223344 survives reset and is read back afterwards.
- Basic write/read: write 0xA5A5_0001 to addr 3, next cycle read addr 3 -> rd_data_o=0xA5A5_0001 one edge after the read request; addr 4 unaffected.
- Hold: after reading addr 3, deassert rd_valid_i and write 0x0 to addr 3 -> rd_data_o stays 0xA5A5_0001 until the next read.
- Read-during-write: mem[7]=0x1111_1111; same edge write 0x2222_2222 to 7 and read 7 -> rd_data_o=0x1111_1111; read again -> 0x2222_2222.
- Back-to-back/boundary: write addr 0=0xCAFE0000 and addr depth_p-1=0x0000BEEF, then read both on consecutive cycles -> correct values each cycle, no aliasing between addr 0 and depth_p-1.
- Non-power-of-two (depth_p=6): write 0x55 to addr 7 -> no entry changes; read addr 7 -> rd_data_o=0.
